ram_byte_bridge: RTL
====================

# ram_byte_bridge

Responder on the core's data-RAM port: it accepts the word-wide, byte-selected requests that the cache issues (ce/we/addr/sel/data) and serves them from a byte-wide external memory. Each request is split into one byte access per enabled lane. Completion is signalled with a one-cycle ready pulse, which the cache uses to release its stall. The block sits between the core's ram_* outputs and the board-level SRAM/ROM byte port.

## Interface
Parameters:
- ADDR_W, 17, external byte-address width.
- RD_LAT, 1, external read latency in cycles; legal values 1..3.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- ram_ce_i  in  1  request valid.
- ram_we_i  in  1  1 = write, 0 = read.
- ram_addr_i  in  32  word address. Bits [1:0] and bits above ADDR_W-1 are ignored.
- ram_sel_i  in  4  byte-lane enables. Lane k = data bits [8k+7:8k].
- ram_data_i  in  32  write data.
- ram_data_o  out  32  read data. Valid while ram_ready_o=1 and held until the next read completes.
- ram_ready_o  out  1  one-cycle completion pulse.
- ext_addr_o  out  ADDR_W  external byte address.
- ext_we_o  out  1  external write strobe.
- ext_dout_o  out  8  external write data.
- ext_din_i  in  8  external read data. Valid RD_LAT cycles after its address is driven.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - If ram_ce_i=1, latch we/addr/sel/data.
  - Go to ACCESS; if sel=0, go to DONE instead.
- ACCESS, lanes processed in ascending order, enabled lanes only; byte address = {addr[ADDR_W-1:2], k[1:0]}.
  - Write: one cycle per enabled lane with ext_we_o=1 and ext_dout_o = lane byte. After the last lane, go to DONE.
  - Read: one address issued per cycle, pipelined. Each issued lane index enters an RD_LAT-deep tag pipe, and ext_din_i is captured into that lane when the tag emerges. After the last issue, ext_addr_o holds the last address for RD_LAT drain cycles, then the FSM goes to DONE.
  - Read lanes with sel=0 return 0x00.
- DONE:
  - ram_ready_o=1 for exactly one cycle.
  - ram_ce_i is ignored in this cycle.
  - Next state is always IDLE.
- The requester holds all request inputs stable from ce assertion until ready. It must deassert ce or present the next request by the cycle after ready.
- Request inputs that change during ACCESS are ignored; the latched copy is used.
- Write transactions leave ram_data_o unchanged.

## Timing
- Reset (rst=0), asynchronous:
  - state=IDLE; ram_ready_o=0, ram_data_o=0, ext_addr_o=0, ext_we_o=0, ext_dout_o=0.
  - Tag pipe cleared; in-flight read bytes discarded.
  - External writes already strobed are not undone.
- In IDLE and DONE: ext_we_o=0, ext_addr_o holds its last value.
- Cycle numbering: the cycle in which IDLE samples ce=1 is cycle 0; n = popcount(sel).
  - Write: strobes in cycles 1..n; ready in cycle n+1.
  - Read: issues in cycles 1..n; last capture at the end of cycle n+RD_LAT; ready in cycle n+RD_LAT+1.
  - sel=0: ready in cycle 1; no external access.
- Throughput: the earliest next request is sampled in the cycle after ready.
  - Full-word write: 6-cycle period.
  - Full-word read at RD_LAT=1: 7-cycle period.
- ext_we_o is never high in a read transaction, in IDLE or DONE, or in the cycle after reset deasserts.

## Structure
- Shared defines file:
  - FSM state encodings (2 bits).
  - Byte-lane count of 4.
  - Lane index width of 2.
  - The existing `RegBus width, reused for the 32-bit buses.
- Sub-module rd_tag_pipe:
  - RD_LAT-deep shift register of {valid, lane[1:0]}.
  - Async active-low reset.
  - Outputs the lane to capture and a capture enable.
- Main block contains: FSM, lane iterator (next enabled lane at or above the current one), request latch, read assembly register.

## Test plan
- Full-word write: addr=0x0000_1004, sel=4'b1111, data=0xA1B2C3D4 → ext writes 0x1004=D4, 0x1005=C3, 0x1006=B2, 0x1007=A1 in cycles 1–4; ready in cycle 5.
- Full-word read, RD_LAT=1: memory bytes 0x10..0x13 = 11,22,33,44 at addr 0x10 → ram_data_o=0x44332211 with ready in cycle 6.
- Sparse read, RD_LAT=3: sel=4'b0101, addr 0x20 → addresses 0x20, 0x22 only; ram_data_o=0x00XX00YY; ready in cycle 6.
- sel=0, ce=1 → no ext_we_o; ready in cycle 1; ram_data_o unchanged.
- Reset mid-read: assert rst=0 during drain cycle 3 of a 4-byte read → all outputs 0 immediately. After release, a new sel=4'b0001 write completes normally with ready in cycle 2.
- Back-to-back: a write request presented in the cycle after ready is sampled there. ram_ce_i toggling or ram_addr_i changing during ACCESS has no effect on the external sequence.

Source files
------------

// File: rtl/ram_byte_bridge_pkg.sv
// Shared encodings, widths and helpers for the word-to-byte RAM bridge.
package ram_byte_bridge_pkg;

    localparam int unsigned REG_BUS   = 32;
    localparam int unsigned NUM_LANES = 4;
    localparam int unsigned LANE_W    = 2;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    typedef struct packed {
        logic              valid;
        logic [LANE_W-1:0] lane;
    } rd_tag_t;

    // Lowest enabled lane at or above start; the top bit flags that one exists.
    function automatic logic [LANE_W:0] next_lane(input logic [NUM_LANES-1:0] sel,
                                                  input logic [LANE_W:0]      start);
        logic [LANE_W:0] res;
        res = '0;
        for (int k = NUM_LANES - 1; k >= 0; k--) begin
            if (sel[k] && ((LANE_W+1)'(k) >= start)) begin
                res = {1'b1, LANE_W'(k)};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ram_byte_bridge_rd_tag_pipe.sv
// Delay line of read lane tags, aligned to the external memory read latency.
module ram_byte_bridge_rd_tag_pipe
    import ram_byte_bridge_pkg::*;
#(
    parameter int unsigned DEPTH = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_i,
    input  logic [LANE_W-1:0] issue_lane_i,
    output logic              cap_en_o,
    output logic [LANE_W-1:0] cap_lane_o
);

    rd_tag_t [DEPTH-1:0] pipe_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pipe_q <= '0;
        end else begin
            pipe_q[0] <= {issue_i, issue_lane_i};
            for (int i = 1; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign cap_en_o   = pipe_q[DEPTH-1].valid;
    assign cap_lane_o = pipe_q[DEPTH-1].lane;

endmodule

// File: rtl/ram_byte_bridge.sv
// Serves word-wide byte-selected RAM requests from a byte-wide external memory,
// one access per enabled lane, finishing with a one-cycle ready pulse.
module ram_byte_bridge
    import ram_byte_bridge_pkg::*;
#(
    parameter int unsigned ADDR_W = 17,
    parameter int unsigned RD_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ram_ce_i,
    input  logic                 ram_we_i,
    input  logic [REG_BUS-1:0]   ram_addr_i,
    input  logic [NUM_LANES-1:0] ram_sel_i,
    input  logic [REG_BUS-1:0]   ram_data_i,
    output logic [REG_BUS-1:0]   ram_data_o,
    output logic                 ram_ready_o,
    output logic [ADDR_W-1:0]    ext_addr_o,
    output logic                 ext_we_o,
    output logic [7:0]           ext_dout_o,
    input  logic [7:0]           ext_din_i
);

    logic [1:0]           state_q, state_d;
    logic                 we_q, we_d;
    logic [ADDR_W-3:0]    addr_q, addr_d;
    logic [NUM_LANES-1:0] sel_q, sel_d;
    logic [REG_BUS-1:0]   wdata_q, wdata_d;
    logic [LANE_W-1:0]    lane_q, lane_d;
    logic                 drain_q, drain_d;
    logic [1:0]           drain_cnt_q, drain_cnt_d;
    logic [REG_BUS-1:0]   rd_buf_q, rd_buf_d;
    logic [REG_BUS-1:0]   rdata_q, rdata_d;
    logic [ADDR_W-1:0]    ext_addr_q, ext_addr_d;
    logic                 ext_we_q, ext_we_d;
    logic [7:0]           ext_dout_q, ext_dout_d;

    logic                 issue;
    logic                 cap_en;
    logic [LANE_W-1:0]    cap_lane;
    logic [LANE_W:0]      first_lane;
    logic [LANE_W:0]      nxt_lane;
    logic                 unused_addr;

    assign unused_addr = ^{ram_addr_i[REG_BUS-1:ADDR_W], ram_addr_i[1:0]};
    assign first_lane  = next_lane(ram_sel_i, '0);
    assign nxt_lane    = next_lane(sel_q, {1'b0, lane_q} + 1'b1);
    assign issue       = (state_q == ST_ACCESS) && !drain_q && !we_q;

    ram_byte_bridge_rd_tag_pipe #(
        .DEPTH(RD_LAT)
    ) u_rd_tag_pipe (
        .clk         (clk),
        .rst         (rst),
        .issue_i     (issue),
        .issue_lane_i(lane_q),
        .cap_en_o    (cap_en),
        .cap_lane_o  (cap_lane)
    );

    // External outputs are registered, so each lane is loaded one cycle ahead.
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        addr_d      = addr_q;
        sel_d       = sel_q;
        wdata_d     = wdata_q;
        lane_d      = lane_q;
        drain_d     = drain_q;
        drain_cnt_d = drain_cnt_q;
        rd_buf_d    = rd_buf_q;
        rdata_d     = rdata_q;
        ext_addr_d  = ext_addr_q;
        ext_we_d    = 1'b0;
        ext_dout_d  = ext_dout_q;

        if (cap_en) begin
            rd_buf_d[{cap_lane, 3'b000} +: 8] = ext_din_i;
        end

        case (state_q)
            ST_IDLE: begin
                if (ram_ce_i) begin
                    we_d     = ram_we_i;
                    addr_d   = ram_addr_i[ADDR_W-1:2];
                    sel_d    = ram_sel_i;
                    wdata_d  = ram_data_i;
                    rd_buf_d = '0;
                    drain_d  = 1'b0;
                    if (first_lane[LANE_W]) begin
                        state_d    = ST_ACCESS;
                        lane_d     = first_lane[LANE_W-1:0];
                        ext_addr_d = {ram_addr_i[ADDR_W-1:2], first_lane[LANE_W-1:0]};
                        ext_we_d   = ram_we_i;
                        ext_dout_d = ram_data_i[{first_lane[LANE_W-1:0], 3'b000} +: 8];
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_ACCESS: begin
                if (!drain_q) begin
                    if (nxt_lane[LANE_W]) begin
                        lane_d     = nxt_lane[LANE_W-1:0];
                        ext_addr_d = {addr_q, nxt_lane[LANE_W-1:0]};
                        ext_we_d   = we_q;
                        ext_dout_d = wdata_q[{nxt_lane[LANE_W-1:0], 3'b000} +: 8];
                    end else if (we_q) begin
                        state_d = ST_DONE;
                    end else begin
                        drain_d     = 1'b1;
                        drain_cnt_d = 2'(RD_LAT - 1);
                    end
                end else if (drain_cnt_q == 2'd0) begin
                    state_d = ST_DONE;
                    drain_d = 1'b0;
                    rdata_d = rd_buf_d;
                end else begin
                    drain_cnt_d = drain_cnt_q - 2'd1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            we_q        <= 1'b0;
            addr_q      <= '0;
            sel_q       <= '0;
            wdata_q     <= '0;
            lane_q      <= '0;
            drain_q     <= 1'b0;
            drain_cnt_q <= '0;
            rd_buf_q    <= '0;
            rdata_q     <= '0;
            ext_addr_q  <= '0;
            ext_we_q    <= 1'b0;
            ext_dout_q  <= '0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            sel_q       <= sel_d;
            wdata_q     <= wdata_d;
            lane_q      <= lane_d;
            drain_q     <= drain_d;
            drain_cnt_q <= drain_cnt_d;
            rd_buf_q    <= rd_buf_d;
            rdata_q     <= rdata_d;
            ext_addr_q  <= ext_addr_d;
            ext_we_q    <= ext_we_d;
            ext_dout_q  <= ext_dout_d;
        end
    end

    assign ram_data_o  = rdata_q;
    assign ram_ready_o = (state_q == ST_DONE);
    assign ext_addr_o  = ext_addr_q;
    assign ext_we_o    = ext_we_q;
    assign ext_dout_o  = ext_dout_q;

endmodule
